// File: rtl/fx2_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : fx2_cmd_decoder
// Brief    : Parses 16-bit host command words from a FIFO into bus writes/CTRL.
// Revision : 1.0 - initial release
// ============================================================================
module fx2_cmd_decoder #(
   parameter int unsigned ADDR_INC = 4,
   parameter int unsigned ERR_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      fifo_q,
   input  logic             fifo_empty,
   output logic             fifo_rdreq,
   output logic             mem_valid,
   input  logic             mem_ready,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_wstrb,
   output logic             cpu_reset,
   output logic             busy,
   output logic [15:0]      cmd_count,
   output logic [ERR_W-1:0] err_count
);

   localparam logic [7:0]  c_OP_WRITE = 8'h01;
   localparam logic [7:0]  c_OP_CTRL  = 8'h02;
   localparam logic [31:0] c_ADDR_INC = 32'(ADDR_INC);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HDR     = 3'd1,
      S_ADDR_HI = 3'd2,
      S_ADDR_LO = 3'd3,
      S_DATA_LO = 3'd4,
      S_DATA_HI = 3'd5,
      S_BUS     = 3'd6
   } state_t;

   state_t           state_q, state_d;
   logic             rd_pend_q, rd_pend_d;
   logic [7:0]       len_q, len_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             valid_q, valid_d;
   logic             cpu_rst_q, cpu_rst_d;
   logic [15:0]      cmd_q, cmd_d;
   logic [ERR_W-1:0] err_q, err_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         rd_pend_q <= 1'b0;
         len_q     <= 8'd0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         valid_q   <= 1'b0;
         cpu_rst_q <= 1'b1;
         cmd_q     <= 16'd0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         rd_pend_q <= rd_pend_d;
         len_q     <= len_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         valid_q   <= valid_d;
         cpu_rst_q <= cpu_rst_d;
         cmd_q     <= cmd_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rd_pend_d  = rd_pend_q;
      len_d      = len_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      valid_d    = valid_q;
      cpu_rst_d  = cpu_rst_q;
      cmd_d      = cmd_q;
      err_d      = err_q;
      fifo_rdreq = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) state_d = S_HDR;
         end
         S_BUS: begin
            if (mem_ready) begin
               valid_d = 1'b0;
               addr_d  = addr_q + c_ADDR_INC;
               len_d   = len_q - 8'd1;
               if (len_q == 8'd1) begin
                  cmd_d   = cmd_q + 16'd1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA_LO;
               end
            end
         end
         default: begin
            // Word-consuming states: fifo_q is valid the cycle after the pop.
            if (rd_pend_q) begin
               rd_pend_d = 1'b0;
               case (state_q)
                  S_HDR: begin
                     if (fifo_q[15:8] == c_OP_WRITE) begin
                        len_d   = fifo_q[7:0];
                        state_d = S_ADDR_HI;
                     end else if (fifo_q[15:8] == c_OP_CTRL) begin
                        cpu_rst_d = fifo_q[0];
                        cmd_d     = cmd_q + 16'd1;
                        state_d   = S_IDLE;
                     end else begin
                        if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
                        state_d = S_IDLE;
                     end
                  end
                  S_ADDR_HI: begin
                     addr_d[31:16] = fifo_q;
                     state_d       = S_ADDR_LO;
                  end
                  S_ADDR_LO: begin
                     addr_d[15:0] = fifo_q;
                     if (len_q == 8'd0) begin
                        cmd_d   = cmd_q + 16'd1;
                        state_d = S_IDLE;
                     end else begin
                        state_d = S_DATA_LO;
                     end
                  end
                  S_DATA_LO: begin
                     wdata_d[15:0] = fifo_q;
                     state_d       = S_DATA_HI;
                  end
                  S_DATA_HI: begin
                     wdata_d[31:16] = fifo_q;
                     valid_d        = 1'b1;
                     state_d        = S_BUS;
                  end
                  default: state_d = S_IDLE;
               endcase
            end else if (!fifo_empty) begin
               fifo_rdreq = 1'b1;
               rd_pend_d  = 1'b1;
            end
         end
      endcase
   end

   assign mem_valid = valid_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = valid_q ? 4'hF : 4'h0;
   assign cpu_reset = cpu_rst_q;
   assign busy      = (state_q != S_IDLE);
   assign cmd_count = cmd_q;
   assign err_count = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fx2_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fx2_cmd_decoder
// Brief    : Randomized self-checking bench with a packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fx2_cmd_decoder;

   localparam int ADDR_INC = 4;
   localparam int ERR_W    = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [15:0]      fifo_q = 16'h0;
   logic             fifo_empty;
   logic             fifo_rdreq;
   logic             mem_valid;
   logic             mem_ready = 1'b0;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic [3:0]       mem_wstrb;
   logic             cpu_reset;
   logic             busy;
   logic [15:0]      cmd_count;
   logic [ERR_W-1:0] err_count;

   int checks = 0;
   int failures = 0;

   logic [15:0] fifo_mem[$];
   int          fifo_cnt = 0;
   logic        force_empty = 1'b0;
   int          ready_mode = 0;  // 0 tied high, 1 five-cycle stall, 2 random, 3 never
   int          empty_mode = 0;  // 0 off, 1 toggle every cycle, 2 random
   int          wait_cnt = 0;

   logic [15:0] model_in[$];
   logic [63:0] exp_q[$];
   logic [63:0] obs_q[$];
   logic [15:0] exp_cmd = 16'h0;
   logic [7:0]  exp_err = 8'h0;
   logic        exp_cpu = 1'b1;
   logic [31:0] data_tab[8];

   logic        prev_valid = 1'b0;
   logic        prev_acc = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   logic [31:0] prev_data = 32'h0;

   assign fifo_empty = (fifo_cnt == 0) || force_empty;

   fx2_cmd_decoder #(.ADDR_INC(ADDR_INC), .ERR_W(ERR_W)) dut (
      .clk(clk), .reset(reset), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
      .fifo_rdreq(fifo_rdreq), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .cpu_reset(cpu_reset), .busy(busy), .cmd_count(cmd_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Non-show-ahead FIFO read side.
   always @(posedge clk) begin
      if (fifo_rdreq && !reset) begin
         checks++;
         if (fifo_empty) begin
            failures++;
            $display("FAIL pop_when_empty rdreq=1 empty=%0b required no pop", fifo_empty);
         end else begin
            fifo_q <= fifo_mem.pop_front();
            fifo_cnt--;
         end
      end
   end

   // Bus responder, empty-flag jitter and bus protocol monitor.
   always @(negedge clk) begin
      case (ready_mode)
         0: mem_ready = 1'b1;
         1: begin
            if (mem_valid) wait_cnt++; else wait_cnt = 0;
            mem_ready = (wait_cnt >= 6);
         end
         2: mem_ready = 1'($urandom_range(0, 1));
         default: mem_ready = 1'b0;
      endcase
      if (empty_mode == 1) force_empty = ~force_empty;
      else if (empty_mode == 2) force_empty = ($urandom_range(0, 3) == 0);
      else force_empty = 1'b0;
      if (!reset) begin
         checks++;
         if (mem_wstrb !== (mem_valid ? 4'hF : 4'h0)) begin
            failures++;
            $display("FAIL wstrb valid=%0b got=%h", mem_valid, mem_wstrb);
         end
         if (mem_valid && prev_valid && !prev_acc) begin
            checks++;
            if (mem_addr !== prev_addr || mem_wdata !== prev_data) begin
               failures++;
               $display("FAIL bus_stable got=%h/%h required=%h/%h",
                        mem_addr, mem_wdata, prev_addr, prev_data);
            end
         end
         if (mem_valid && mem_ready) obs_q.push_back({mem_addr, mem_wdata});
         prev_valid = mem_valid;
         prev_acc   = mem_valid && mem_ready;
         prev_addr  = mem_addr;
         prev_data  = mem_wdata;
      end else begin
         prev_valid = 1'b0;
      end
   end

   task automatic push_word(input logic [15:0] w);
      fifo_mem.push_back(w);
      fifo_cnt++;
      model_in.push_back(w);
   endtask

   task automatic push_write(input logic [31:0] a, input int len);
      push_word({8'h01, 8'(len)});
      push_word(a[31:16]);
      push_word(a[15:0]);
      for (int i = 0; i < len; i++) begin
         push_word(data_tab[i][15:0]);
         push_word(data_tab[i][31:16]);
      end
   endtask

   // Reference: walk whole packets and list the writes they imply.
   task automatic model_parse();
      logic [15:0] hdr, hi, lo;
      logic [31:0] a;
      while (model_in.size() > 0) begin
         hdr = model_in.pop_front();
         if (hdr[15:8] == 8'h01) begin
            hi = model_in.pop_front();
            lo = model_in.pop_front();
            a  = {hi, lo};
            for (int i = 0; i < int'(hdr[7:0]); i++) begin
               lo = model_in.pop_front();
               hi = model_in.pop_front();
               exp_q.push_back({a, hi, lo});
               a = a + 32'(ADDR_INC);
            end
            exp_cmd = exp_cmd + 16'd1;
         end else if (hdr[15:8] == 8'h02) begin
            exp_cpu = hdr[0];
            exp_cmd = exp_cmd + 16'd1;
         end else if (exp_err != 8'hFF) begin
            exp_err = exp_err + 8'd1;
         end
      end
   endtask

   task automatic wait_idle(input string name);
      int quiet = 0;
      int budget = 0;
      while (quiet < 3 && budget < 20000) begin
         @(negedge clk);
         budget++;
         if (!busy && fifo_cnt == 0) quiet++; else quiet = 0;
      end
      checks++;
      if (quiet < 3) begin
         failures++;
         $display("FAIL %s_timeout busy=%0b fifo_left=%0d required idle", name, busy, fifo_cnt);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({fifo_rdreq, mem_valid, busy, cpu_reset} !== 4'b0001) begin
         failures++;
         $display("FAIL reset_ctrl got=%b required=0001", {fifo_rdreq, mem_valid, busy, cpu_reset});
      end
      checks++;
      if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin
         failures++;
         $display("FAIL reset_bus got=%h/%h/%h required 0", mem_addr, mem_wdata, mem_wstrb);
      end
      checks++;
      if (cmd_count !== 16'h0 || err_count !== 8'h0) begin
         failures++;
         $display("FAIL reset_counts got=%h/%h required 0/0", cmd_count, err_count);
      end
      reset = 1'b0;
   endtask

   task automatic test_ctrl(input logic [15:0] hdr);
      push_word(hdr);
      wait_idle("ctrl");
      model_parse();
      checks++;
      if (cpu_reset !== exp_cpu || cmd_count !== exp_cmd) begin
         failures++;
         $display("FAIL ctrl_%h got cpu=%b cmd=%0d required cpu=%b cmd=%0d",
                  hdr, cpu_reset, cmd_count, exp_cpu, exp_cmd);
      end
   endtask

   task automatic test_write(input string name, input logic [31:0] a, input int len,
                             input int rmode, input int emode);
      ready_mode = rmode;
      empty_mode = emode;
      push_write(a, len);
      wait_idle(name);
      ready_mode = 0;
      empty_mode = 0;
      model_parse();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL %s_nwrites got=%0d required=%0d", name, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL %s_write%0d got=%h required=%h", name, i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if (cmd_count !== exp_cmd) begin
         failures++;
         $display("FAIL %s_cmd got=%0d required=%0d", name, cmd_count, exp_cmd);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_stall();
      data_tab[0] = 32'hDEADBEEF;
      data_tab[1] = 32'h12345678;
      test_write("stall", 32'h0000_1000, 2, 1, 1);
   endtask

   task automatic test_err_len0();
      push_word(16'h7F00);
      push_word(16'h0100);
      push_word(16'h0000);
      push_word(16'h0000);
      wait_idle("err_len0");
      model_parse();
      checks++;
      if (err_count !== 8'h01 || err_count !== exp_err || cmd_count !== exp_cmd || obs_q.size() != 0) begin
         failures++;
         $display("FAIL err_len0 got err=%0d cmd=%0d writes=%0d required err=1 cmd=%0d writes=0",
                  err_count, cmd_count, obs_q.size(), exp_cmd);
      end
      for (int i = 0; i < 256; i++) push_word({8'($urandom_range(3, 255)), 8'($urandom)});
      wait_idle("err_sat");
      model_parse();
      checks++;
      if (err_count !== 8'hFF || exp_err !== 8'hFF || cmd_count !== exp_cmd) begin
         failures++;
         $display("FAIL err_sat got err=%h cmd=%0d required err=ff cmd=%0d",
                  err_count, cmd_count, exp_cmd);
      end
      obs_q.delete();
   endtask

   task automatic test_wrap();
      data_tab[0] = $urandom;
      data_tab[1] = $urandom;
      test_write("wrap", 32'hFFFF_FFFC, 2, 2, 2);
   endtask

   task automatic test_random();
      ready_mode = 2;
      empty_mode = 2;
      for (int p = 0; p < 40; p++) begin
         int kind = $urandom_range(0, 9);
         if (kind < 6) begin
            for (int i = 0; i < 8; i++) data_tab[i] = $urandom;
            push_write($urandom, $urandom_range(0, 5));
         end else if (kind < 8) begin
            push_word({8'h02, 8'($urandom)});
         end else begin
            push_word({8'($urandom_range(3, 255)), 8'($urandom)});
         end
      end
      wait_idle("random");
      ready_mode = 0;
      empty_mode = 0;
      model_parse();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL random_nwrites got=%0d required=%0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL random_write%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if (cmd_count !== exp_cmd || err_count !== exp_err || cpu_reset !== exp_cpu) begin
         failures++;
         $display("FAIL random_state got cmd=%0d err=%0d cpu=%b required cmd=%0d err=%0d cpu=%b",
                  cmd_count, err_count, cpu_reset, exp_cmd, exp_err, exp_cpu);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset_bus();
      int budget = 0;
      ready_mode = 3;
      for (int i = 0; i < 3; i++) data_tab[i] = $urandom;
      push_write(32'h0000_2000, 3);
      while (!mem_valid && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      checks++;
      if (!mem_valid) begin
         failures++;
         $display("FAIL reset_bus_reach got valid=%b required 1", mem_valid);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({mem_valid, busy, cpu_reset, mem_wstrb} !== 7'b0010000 || cmd_count !== 16'h0 || err_count !== 8'h0) begin
         failures++;
         $display("FAIL reset_bus got valid=%b busy=%b cpu=%b strb=%h cmd=%0d err=%0d required 0/0/1/0/0/0",
                  mem_valid, busy, cpu_reset, mem_wstrb, cmd_count, err_count);
      end
      fifo_mem.delete();
      fifo_cnt = 0;
      model_in.delete();
      obs_q.delete();
      exp_q.delete();
      exp_cmd = 16'h0;
      exp_err = 8'h0;
      exp_cpu = 1'b1;
      ready_mode = 0;
      @(negedge clk);
      reset = 1'b0;
      test_ctrl(16'h0200);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) data_tab[i] = 32'h0;
      test_reset();
      test_ctrl(16'h0200);
      test_ctrl(16'h0201);
      data_tab[0] = 32'hDEADBEEF;
      data_tab[1] = 32'h12345678;
      test_write("write", 32'h0000_1000, 2, 0, 0);
      test_stall();
      test_err_len0();
      test_wrap();
      test_random();
      test_reset_bus();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
